// File: rtl/spi_rx_deser.sv
// spi_rx_deser: oversampled SPI slave receive deserialiser, run-time SPI mode, valid/ready word output
// Define SPI_RX_SYNC_EN to add 2-flop synchronisers on sclk, cs_n and mosi.
module spi_rx_deser #(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 0,
  parameter int MULTI_WORD = 1,
  parameter int CNT_W      = $clog2(DATA_W + 1)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              frame_err,
  output logic              overrun_err,
  input  logic              err_clr
);
  typedef enum logic [2:0] {IDLE, WAIT_CS, SHIFT, DONE, OVF_CHK, ERROR} state_t;
  state_t r_state, w_next;
  logic w_sclk, w_cs_n, w_mosi;
`ifdef SPI_RX_SYNC_EN
  logic [1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  always_ff @(posedge clk_in) begin
    r_sclk_sync <= {r_sclk_sync[0], sclk};
    r_cs_sync   <= {r_cs_sync[0], cs_n};
    r_mosi_sync <= {r_mosi_sync[0], mosi};
  end
  assign w_sclk = r_sclk_sync[1];
  assign w_cs_n = r_cs_sync[1];
  assign w_mosi = r_mosi_sync[1];
`else
  assign w_sclk = sclk;
  assign w_cs_n = cs_n;
  assign w_mosi = mosi;
`endif
  logic r_sclk_cur, r_sclk_prev, r_cpol, r_cpha;
  logic [DATA_W-1:0] r_shift;
  logic w_edge, w_shift, w_ferr, w_load, w_ovr;
  // modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising edge
  assign w_edge = (r_cpol ^ r_cpha) ? (~r_sclk_cur & r_sclk_prev) : (r_sclk_cur & ~r_sclk_prev);
  assign w_load = (r_state == DONE) & (~rx_valid | rx_ready);
  assign w_ovr  = (r_state == DONE) & rx_valid & ~rx_ready;
  assign busy   = (r_state == SHIFT) | (r_state == DONE);
  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      IDLE:    w_next = WAIT_CS;
      WAIT_CS: w_next = w_cs_n ? WAIT_CS : SHIFT;
      SHIFT: begin
        if (w_cs_n) begin
          w_next = (bit_cnt == '0) ? IDLE : ERROR;
          w_ferr = (bit_cnt != '0);
        end else if (w_edge) begin
          w_shift = 1'b1;
          w_next  = (bit_cnt == CNT_W'(DATA_W - 1)) ? DONE : SHIFT;
        end
      end
      DONE:    w_next = w_cs_n ? IDLE : ((MULTI_WORD != 0) ? SHIFT : OVF_CHK);
      OVF_CHK: begin
        w_next = w_cs_n ? IDLE : (w_edge ? ERROR : OVF_CHK);
        w_ferr = ~w_cs_n & w_edge;
      end
      ERROR:   w_next = w_cs_n ? IDLE : ERROR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sclk_cur  <= w_sclk;
      r_sclk_prev <= w_sclk;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_shift     <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      r_sclk_cur  <= w_sclk;
      r_sclk_prev <= r_sclk_cur;
      if (r_state == IDLE) begin
        r_shift <= '0;
        bit_cnt <= '0;
        r_cpol  <= cpol;
        r_cpha  <= cpha;
      end else if (w_shift) begin
        r_shift <= (LSB_FIRST != 0) ? {w_mosi, r_shift[DATA_W-1:1]} : {r_shift[DATA_W-2:0], w_mosi};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (r_state == DONE) begin
        bit_cnt <= '0;
      end
      if (w_load) rx_data <= r_shift;
      rx_valid    <= w_load | (rx_valid & ~rx_ready);
      frame_err   <= w_ferr | (frame_err & ~err_clr);
      overrun_err <= w_ovr | (overrun_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: randomized SPI frames against a word-queue reference model for spi_rx_deser
module tb_spi_rx_deser;
  localparam int H = 8;
`ifdef SPI_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, sclk = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0, err_clr = 1'b0;
  logic cs8 = 1'b1, cs16 = 1'b1, cssw = 1'b1, rdy8 = 1'b0;
  logic [7:0] d8, dsw;
  logic [15:0] d16;
  logic [3:0] c8, csw;
  logic [4:0] c16;
  logic v8, b8, fe8, oe8, v16, b16, fe16, oe16, vsw, bsw, fesw, oesw;
  logic [31:0] got8[$], got16[$], gotsw[$], exp8[$], exp16[$];
  int n_chk = 0, n_fail = 0;

  spi_rx_deser #(.DATA_W(8)) u8 (
    .clk_in(clk), .reset(reset), .sclk(sclk), .cs_n(cs8), .mosi(mosi), .cpol(cpol), .cpha(cpha),
    .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8), .busy(b8), .bit_cnt(c8),
    .frame_err(fe8), .overrun_err(oe8), .err_clr(err_clr));
  spi_rx_deser #(.DATA_W(16), .LSB_FIRST(1)) u16 (
    .clk_in(clk), .reset(reset), .sclk(sclk), .cs_n(cs16), .mosi(mosi), .cpol(cpol), .cpha(cpha),
    .rx_data(d16), .rx_valid(v16), .rx_ready(1'b1), .busy(b16), .bit_cnt(c16),
    .frame_err(fe16), .overrun_err(oe16), .err_clr(err_clr));
  spi_rx_deser #(.DATA_W(8), .MULTI_WORD(0)) usw (
    .clk_in(clk), .reset(reset), .sclk(sclk), .cs_n(cssw), .mosi(mosi), .cpol(cpol), .cpha(cpha),
    .rx_data(dsw), .rx_valid(vsw), .rx_ready(1'b1), .busy(bsw), .bit_cnt(csw),
    .frame_err(fesw), .overrun_err(oesw), .err_clr(err_clr));

  always @(posedge clk) begin
    if (!reset && v8 && rdy8) got8.push_back({24'd0, d8});
    if (!reset && v16) got16.push_back({16'd0, d16});
    if (!reset && vsw) gotsw.push_back({24'd0, dsw});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input int sel, input string tag, input logic [31:0] e);
    logic [31:0] g;
    g = 'x;
    case (sel)
      0: if (got8.size() != 0) g = got8.pop_front();
      1: if (got16.size() != 0) g = got16.pop_front();
      default: if (gotsw.size() != 0) g = gotsw.pop_front();
    endcase
    chk(tag, g, e);
  endtask

  // data is made wrong around the non-sampling edge so a wrong-edge capture shows up
  task automatic drive_bit(input logic b, input bit stop);
    if (!cpha) begin
      mosi = b; tick(H); sclk = ~cpol;
      if (!stop) begin tick(H/2); mosi = ~b; tick(H/2); sclk = cpol; end
    end else begin
      sclk = ~cpol; mosi = ~b; tick(H/2); mosi = b; tick(H/2); sclk = cpol;
      if (!stop) tick(H);
    end
  endtask

  task automatic finish_bit();
    tick(H); sclk = cpol; tick(H);
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input bit lsb, input bit stop_last);
    for (int i = 0; i < n; i++) drive_bit(lsb ? v[i] : v[n-1-i], stop_last && (i == n - 1));
  endtask

  task automatic set_mode(input int m);
    cpol = m[1]; cpha = m[0]; sclk = m[1]; tick(4);
    cs8 = 1'b0; cs16 = 1'b0; cssw = 1'b0; tick(3);
    cs8 = 1'b1; cs16 = 1'b1; cssw = 1'b1; tick(H);
  endtask

  initial begin
    tick(4);
    chk("rst_valid", v8, 0); chk("rst_busy", b8, 0); chk("rst_cnt", c8, 0);
    chk("rst_ferr", fe8, 0); chk("rst_oerr", oe8, 0); chk("rst_data", d8, 0);
    reset = 1'b0; tick(3);
    // mode 0 latency: valid two cycles after the cycle that registers the last rising sclk
    cs8 = 1'b0; tick(H);
    send_word(32'hA5, 8, 0, 1);
    tick(1 + SYNC); chk("lat_n1_valid", v8, 0);
    tick(1); chk("lat_n2_valid", v8, 0); chk("lat_busy", b8, 1); chk("lat_cnt8", c8, 8);
    tick(1); chk("lat_n3_valid", v8, 1); chk("lat_data", d8, 32'hA5); chk("lat_cnt0", c8, 0);
    finish_bit(); cs8 = 1'b1; tick(H);
    chk("m0_ferr", fe8, 0);
    rdy8 = 1'b1; tick(2);
    chk("m0_consumed", v8, 0);
    expect_word(0, "m0_word", 32'hA5);
    for (int m = 1; m < 4; m++) begin
      set_mode(m);
      chk("mode_dummy_ferr", fe8, 0);
      cs8 = 1'b0; tick(H); send_word(32'h3C, 8, 0, 0); tick(H); cs8 = 1'b1; tick(H);
      expect_word(0, $sformatf("mode%0d_word", m), 32'h3C);
    end
    set_mode(0);
    cs8 = 1'b0; tick(H); send_word(32'h12, 8, 0, 0); send_word(32'h34, 8, 0, 0); tick(H); cs8 = 1'b1; tick(H);
    expect_word(0, "mw_first", 32'h12); expect_word(0, "mw_second", 32'h34);
    chk("mw_oerr", oe8, 0);
    // overrun with consumer stalled
    rdy8 = 1'b0;
    cs8 = 1'b0; tick(H); send_word(32'h55, 8, 0, 0); send_word(32'hAA, 8, 0, 0); tick(H);
    chk("ovr_data", d8, 32'h55); chk("ovr_valid", v8, 1); chk("ovr_flag", oe8, 1);
    cs8 = 1'b1; tick(H);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("ovr_clr", oe8, 0); chk("ovr_ferr", fe8, 0);
    // accept in the same cycle a new word completes: no overrun
    cs8 = 1'b0; tick(H); send_word(32'h66, 8, 0, 1);
    tick(2 + SYNC); rdy8 = 1'b1; tick(1); rdy8 = 1'b0;
    chk("simul_data", d8, 32'h66); chk("simul_valid", v8, 1); chk("simul_oerr", oe8, 0);
    finish_bit(); cs8 = 1'b1; tick(H);
    rdy8 = 1'b1; tick(2);
    chk("simul_drained", v8, 0);
    expect_word(0, "simul_old", 32'h55); expect_word(0, "simul_new", 32'h66);
    // truncated frame
    cs8 = 1'b0; tick(H); send_word(32'h16, 5, 0, 0); tick(H); cs8 = 1'b1; tick(H);
    chk("fe_flag", fe8, 1); chk("fe_busy", b8, 0); chk("fe_cnt", c8, 0);
    cs8 = 1'b0; tick(H); send_word(32'h0F, 8, 0, 0); tick(H); cs8 = 1'b1; tick(H);
    expect_word(0, "fe_recover", 32'h0F);
    chk("fe_sticky", fe8, 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("fe_clr", fe8, 0);
    // single-word build: an extra sample edge after a full word is a framing error
    cssw = 1'b0; tick(H); send_word(32'h5A, 8, 0, 0); tick(H);
    chk("sw_no_err", fesw, 0);
    send_word(32'h1, 1, 0, 0); tick(H);
    chk("sw_ovf_err", fesw, 1);
    cssw = 1'b1; tick(H);
    expect_word(2, "sw_word", 32'h5A);
    cs16 = 1'b0; tick(H); send_word(32'h8001, 16, 1, 0); tick(H); cs16 = 1'b1; tick(H);
    expect_word(1, "lsb_8001", 32'h8001);
    for (int k = 0; k < 6; k++) begin
      int nw;
      logic [31:0] v;
      set_mode(int'($urandom_range(0, 3)));
      nw = int'($urandom_range(1, 3));
      cs8 = 1'b0; tick(H);
      for (int w = 0; w < nw; w++) begin
        v = $urandom & 32'hFF; exp8.push_back(v); send_word(v, 8, 0, 0);
      end
      tick(H); cs8 = 1'b1; tick(H);
      nw = int'($urandom_range(1, 2));
      cs16 = 1'b0; tick(H);
      for (int w = 0; w < nw; w++) begin
        v = $urandom & 32'hFFFF; exp16.push_back(v); send_word(v, 16, 1, 0);
      end
      tick(H); cs16 = 1'b1; tick(H);
      while (exp8.size() != 0) expect_word(0, "rnd8", exp8.pop_front());
      while (exp16.size() != 0) expect_word(1, "rnd16", exp16.pop_front());
      chk("rnd_ferr8", fe8, 0); chk("rnd_oerr16", oe16, 0);
    end
    // reset mid-frame
    set_mode(0);
    cs16 = 1'b0; tick(H); send_word(32'h1234, 7, 1, 0);
    reset = 1'b1; tick(1); reset = 1'b0;
    cs16 = 1'b1; tick(H);
    chk("rmf_ferr", fe16, 0); chk("rmf_valid", v16, 0); chk("rmf_busy", b16, 0); chk("rmf_cnt", c16, 0);
    cs16 = 1'b0; tick(H); send_word(32'hBEEF, 16, 1, 0); tick(H); cs16 = 1'b1; tick(H);
    expect_word(1, "rmf_recover", 32'hBEEF);
    chk("extra8", 32'(got8.size()), 0);
    chk("extra16", 32'(got16.size()), 0);
    chk("extrasw", 32'(gotsw.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_rx_deser.md
Name: spi_rx_deser

Overview:
- Parametrised SPI slave receive deserialiser; successor to the fixed 8-bit receiver.
- Oversamples SCLK, CS_N and MOSI on the fast system clock and supports all four SPI modes at run time.
- Supports MSB- or LSB-first framing, configurable word width and back-to-back words within one chip-select window.
- Delivers words on a valid/ready interface with framing and overrun error detection; sits between the SPI pads and the register or command decoder.

Parameters:
- DATA_W, 8: bits per word, 2..32.
- LSB_FIRST, 0: 0 = first received bit lands in rx_data[DATA_W-1]; 1 = first bit lands in rx_data[0].
- MULTI_WORD, 1: 1 = bit counter wraps and a new word starts while CS_N stays low; 0 = extra sample edges after a full word raise frame_err.
- CNT_W, $clog2(DATA_W+1): bit counter width.

Ports:
- clk_in  in  1  system clock; must be at least 4x the SCLK frequency.
- reset  in  1  synchronous, active-high.
- sclk  in  1  SPI serial clock.
- cs_n  in  1  chip select, active-low.
- mosi  in  1  serial data in.
- cpol  in  1  clock polarity, sampled only in IDLE/WAIT_CS.
- cpha  in  1  clock phase, sampled only in IDLE/WAIT_CS.
- rx_data  out  DATA_W  received word, stable while rx_valid=1.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts word.
- busy  out  1  high in SHIFT and DONE.
- bit_cnt  out  CNT_W  bits received in the current word.
- frame_err  out  1  sticky: CS_N deasserted mid-word, or overflow when MULTI_WORD=0.
- overrun_err  out  1  sticky: word completed while the previous word was unconsumed.
- err_clr  in  1  single-cycle clear of both sticky flags.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, bit_cnt=0, shift register=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun_err=0. Edge-detect registers load the current sclk value so no false edge occurs on the first cycle.
- Edge detect: a 2-flop history of sclk on clk_in (cur, prev). rise = cur & ~prev; fall = ~cur & prev.
  - Sample edge = rise when cpol^cpha=0, else fall.
  - cpol and cpha are latched into internal registers on the IDLE->WAIT_CS transition.
- States:
  - IDLE: clear bit_cnt and the shift register; go to WAIT_CS next cycle.
  - WAIT_CS: when cs_n=0, go to SHIFT; otherwise stay.
  - SHIFT: on each sample edge, shift mosi in (left shift when LSB_FIRST=0, right shift otherwise) and increment bit_cnt.
    - When bit_cnt reaches DATA_W on an edge, go to DONE.
    - cs_n=1 with bit_cnt=0: go to IDLE, no flag.
    - cs_n=1 with 0<bit_cnt<DATA_W: set frame_err and go to ERROR.
  - DONE (one cycle):
    - If rx_valid=0 or rx_ready=1 this cycle: rx_data <= shift register, rx_valid <= 1.
    - Otherwise: set overrun_err; the new word is dropped and rx_data keeps the old word.
    - bit_cnt <= 0.
    - Next state: SHIFT if cs_n=0 and MULTI_WORD=1; IDLE if cs_n=1; OVERFLOW_CHK if cs_n=0 and MULTI_WORD=0.
  - OVERFLOW_CHK: a sample edge sets frame_err and goes to ERROR; cs_n=1 goes to IDLE.
  - ERROR: hold until cs_n=1, then go to IDLE. No shifting in this state.
- Latency: rx_valid rises 2 clk_in cycles after the clk_in edge at which the last sample edge is detected (one cycle into DONE, one cycle to register).
- Handshake:
  - rx_valid clears on the cycle after rx_valid & rx_ready, unless DONE loads a new word in that same cycle; then rx_valid stays 1 and rx_data updates.
  - Simultaneous accept and complete is not an overrun.
- err_clr in the same cycle as a new error: the set wins.
- Reset mid-frame: aborts immediately to IDLE with no flags. Bits already received are lost; the next frame starts only after WAIT_CS sees cs_n=0.
- CS_N deassertion takes priority over a sample edge detected in the same cycle.

Optional Feature:
- SPI_RX_SYNC_EN
  - Defined: sclk, cs_n and mosi each pass through a 2-flop synchroniser before edge detection and the FSM. All latencies grow by 2 clk_in cycles.
  - Undefined: inputs are used directly. They must be synchronous to clk_in, as in on-chip loopback.

Test Plan:
- Mode 0, DATA_W=8, MSB first: send 0xA5, then raise cs_n. rx_data=0xA5 and rx_valid=1 exactly 2 cycles after the 8th rising sclk. frame_err=0.
- Modes 1, 2 and 3 each send 0x3C. Capture happens on the correct edge each time, and rx_data=0x3C.
- MULTI_WORD=1, rx_ready=1: send 0x12, 0x34 in one CS window. Two rx_valid pulses with 0x12, then 0x34. overrun_err=0.
- rx_ready held 0: send 0x55, then 0xAA. rx_data stays 0x55 and overrun_err=1. err_clr returns overrun_err to 0.
- Raise cs_n after 5 bits: frame_err=1 and state returns to IDLE. A following full 0x0F frame is received correctly.
- LSB_FIRST=1, DATA_W=16: send bit stream 0x8001 LSB first. rx_data=0x8001. Assert reset mid-frame on a repeat: no flags, no rx_valid.
